// File: rtl/alu_issue_ctrl_if.sv
// Request, result and downstream-ALU signals of the ALU issue controller.
interface alu_issue_ctrl_if #(
    parameter int unsigned data_width = 16,
    parameter int unsigned cmd_width  = 3
);
    logic                  req_valid;
    logic                  req_ready;
    logic [cmd_width-1:0]  req_cmd;
    logic [data_width-1:0] req_a;
    logic [data_width-1:0] req_b;

    logic                  res_valid;
    logic                  res_ready;
    logic [data_width-1:0] res_data;
    logic                  res_err;

    logic [data_width-1:0] alu_ain;
    logic [data_width-1:0] alu_bin;
    logic [cmd_width-1:0]  alu_cmd;
    logic [data_width-1:0] alu_outr;

    // Controller side
    modport slave (
        input  req_valid, req_cmd, req_a, req_b, res_ready, alu_outr,
        output req_ready, res_valid, res_data, res_err, alu_ain, alu_bin, alu_cmd
    );

    // Environment side: request producer, result consumer and ALU
    modport master (
        output req_valid, req_cmd, req_a, req_b, res_ready, alu_outr,
        input  req_ready, res_valid, res_data, res_err, alu_ain, alu_bin, alu_cmd
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues queued ALU requests to an external two-stage ALU and collects results
// in order, using a credit count so the result FIFO can never overflow.
module alu_issue_ctrl #(
    parameter int unsigned data_width = 16,
    parameter int unsigned cmd_width  = 3,
    parameter int unsigned depth      = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_issue_ctrl_if.slave bus
);
    localparam int unsigned ptr_w = $clog2(depth);
    localparam int unsigned cnt_w = ptr_w + 1;
    localparam logic [cmd_width-1:0] cmd_hold      = '1;
    localparam logic [cmd_width-1:0] cmd_max_legal = cmd_width'(4);

    typedef logic [data_width-1:0] data_t;
    typedef logic [cmd_width-1:0]  cmd_t;

    // Request FIFO
    data_t            rq_a_q [depth];
    data_t            rq_b_q [depth];
    cmd_t             rq_cmd_q [depth];
    logic [ptr_w-1:0] rq_wr_q, rq_rd_q, rq_rd_d;
    logic [cnt_w-1:0] rq_cnt_q, rq_cnt_d;
    logic             req_ready_q;
    logic             rq_push, rq_pop, rq_rest_empty;

    // Issue stage: head captured one edge ahead so ALU operands are registered
    data_t            head_a_d, head_b_d;
    cmd_t             head_cmd_d, head_cmd_q;
    logic             head_illegal_d, issue_d;
    data_t            alu_ain_q, alu_bin_q;
    cmd_t             alu_cmd_q;
    logic [cnt_w-1:0] credit_q, credit_d;

    // Tag pipeline: stage 0 is the issue cycle, stage 2 the result-write cycle
    logic [2:0]       tag_v_q, tag_e_q;

    // Result FIFO
    data_t            rs_data_q [depth];
    logic [depth-1:0] rs_err_q;
    logic [ptr_w-1:0] rs_wr_q, rs_rd_q;
    logic [cnt_w-1:0] rs_cnt_q, rs_cnt_d;
    logic             res_valid_q;
    logic             rs_push, rs_pop;

    // Next-state: FIFO counts, credits and the head as seen after this edge
    always_comb begin
        rq_push        = bus.req_valid && req_ready_q;
        rq_pop         = tag_v_q[0];
        rs_push        = tag_v_q[2];
        rs_pop         = res_valid_q && bus.res_ready;
        rq_rd_d        = rq_rd_q + ptr_w'(rq_pop);
        rq_cnt_d       = rq_cnt_q + cnt_w'(rq_push) - cnt_w'(rq_pop);
        rs_cnt_d       = rs_cnt_q + cnt_w'(rs_push) - cnt_w'(rs_pop);
        credit_d       = credit_q + cnt_w'(rq_pop) - cnt_w'(rs_pop);
        rq_rest_empty  = (rq_cnt_q == cnt_w'(rq_pop));
        head_a_d       = rq_rest_empty ? bus.req_a   : rq_a_q[rq_rd_d];
        head_b_d       = rq_rest_empty ? bus.req_b   : rq_b_q[rq_rd_d];
        head_cmd_d     = rq_rest_empty ? bus.req_cmd : rq_cmd_q[rq_rd_d];
        head_illegal_d = (head_cmd_d > cmd_max_legal);
        issue_d        = (rq_cnt_d != '0) && (credit_d < cnt_w'(depth));
    end

    // State registers: FIFOs, issue/ALU outputs, tag pipeline, credits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq_a_q      <= '{default: '0};
            rq_b_q      <= '{default: '0};
            rq_cmd_q    <= '{default: '0};
            rq_wr_q     <= '0;
            rq_rd_q     <= '0;
            rq_cnt_q    <= '0;
            req_ready_q <= 1'b1;
            head_cmd_q  <= '0;
            alu_ain_q   <= '0;
            alu_bin_q   <= '0;
            alu_cmd_q   <= cmd_hold;
            credit_q    <= '0;
            tag_v_q     <= '0;
            tag_e_q     <= '0;
            rs_data_q   <= '{default: '0};
            rs_err_q    <= '0;
            rs_wr_q     <= '0;
            rs_rd_q     <= '0;
            rs_cnt_q    <= '0;
            res_valid_q <= 1'b0;
        end else begin
            if (rq_push) begin
                rq_a_q[rq_wr_q]   <= bus.req_a;
                rq_b_q[rq_wr_q]   <= bus.req_b;
                rq_cmd_q[rq_wr_q] <= bus.req_cmd;
                rq_wr_q           <= rq_wr_q + ptr_w'(1);
            end
            rq_rd_q     <= rq_rd_d;
            rq_cnt_q    <= rq_cnt_d;
            req_ready_q <= (rq_cnt_d != cnt_w'(depth));
            credit_q    <= credit_d;

            if (issue_d) begin
                alu_ain_q  <= head_a_d;
                alu_bin_q  <= head_b_d;
                head_cmd_q <= head_cmd_d;
            end
            // Command follows its operands by one cycle; illegal ops hold the ALU
            alu_cmd_q <= (tag_v_q[0] && !tag_e_q[0]) ? head_cmd_q : cmd_hold;
            tag_v_q   <= {tag_v_q[1:0], issue_d};
            tag_e_q   <= {tag_e_q[1:0], head_illegal_d};

            if (rs_push) begin
                rs_data_q[rs_wr_q] <= tag_e_q[2] ? '0 : bus.alu_outr;
                rs_err_q[rs_wr_q]  <= tag_e_q[2];
                rs_wr_q            <= rs_wr_q + ptr_w'(1);
            end
            if (rs_pop) begin
                rs_rd_q <= rs_rd_q + ptr_w'(1);
            end
            rs_cnt_q    <= rs_cnt_d;
            res_valid_q <= (rs_cnt_d != '0);
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = rs_data_q[rs_rd_q];
    assign bus.res_err   = rs_err_q[rs_rd_q];
    assign bus.alu_ain   = alu_ain_q;
    assign bus.alu_bin   = alu_bin_q;
    assign bus.alu_cmd   = alu_cmd_q;
endmodule
